instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//   Inverse of the pipelined control decoder. Accepts symbolic instruction
//   requests (kind + register/immediate fields) and packs each one into a 32-bit
//   MIPS-Lite word. Each packed word is written sequentially into instruction
//   memory. Used by the bench/boot path to build programs for the pipelined CPU.
// PARAMETERS
//   ADDR_W     10  instruction-memory byte-address width
//   BASE_ADDR  0   byte address of first word; must be a multiple of 4
//   DEPTH      256 maximum number of words written per program
// PORTS
//   clk          in   1       clock, rising edge
//   rst_n        in   1       synchronous, active-low reset
//   start_i      in   1       clear pointer/count/error (honoured only in IDLE)
//   in_valid     in   1       request valid
//   in_ready     out  1       request accepted when in_valid&&in_ready
//   in_kind      in   4       0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 SRL,6 JR,7 MULTU,
//                             8 ANDI,9 LW,10 SW,11 BEQ,12 J; 13-15 illegal
//   in_rs/in_rt/in_rd/in_shamt in 5 each  register and shift fields
//   in_imm       in   16      I-type immediate, passed through raw
//   in_target    in   26      J-type word target
//   im_we        out  1       instruction-memory write strobe
//   im_addr      out  ADDR_W  byte address of write
//   im_wdata     out  32      encoded instruction word
//   word_count   out  $clog2(DEPTH+1)  words written since start/reset
//   full         out  1       word_count==DEPTH
//   err_illegal  out  1       sticky: an illegal kind was accepted
// BEHAVIOUR
//   - Reset: state IDLE; im_we=0, im_addr=BASE_ADDR, im_wdata=0, word_count=0,
//     full=0, err_illegal=0. Any write in flight is aborted.
//   - in_ready = (state==IDLE) && !full && !start_i (combinational).
//   - start_i in IDLE: pointer=BASE_ADDR, count=0, err cleared; beats in_valid.
//     start_i is ignored in WRITE/PAD.
//   - Encoding, fields {op,rs,rt,rd,shamt,funct}/{op,rs,rt,imm}/{op,target}:
//     ADD/SUB/AND/OR/SLT -> op 0, funct 32/34/36/37/42, shamt forced 0.
//     SRL -> op 0, rs=0, funct 2. JR -> {0,rs,15'b0,8}. MULTU -> {0,rs,rt,10'b0,25}.
//     ANDI/LW/SW/BEQ -> op 12/35/43/4 with imm. J -> op 2 with target.
//   - FSM: IDLE --accept legal--> WRITE --(NOP_PAD_EN && kind in {BEQ,J,JR} &&
//     !full after write)--> PAD --> IDLE; otherwise WRITE --> IDLE.
//   - Accept is registered: accept at cycle N -> im_we=1 for exactly cycle N+1,
//     with im_addr=pointer and im_wdata=word. Throughput: 1 word / 2 cycles.
//   - At the end of each write cycle: pointer += 4, wrapping modulo 2^ADDR_W;
//     word_count += 1. full becomes 1 when word_count reaches DEPTH.
//   - Illegal kind: consumed in IDLE, no write, err_illegal=1, stay IDLE.
//   - Full: in_ready=0 until start_i; no further writes; word_count saturates.
//   - im_wdata holds the last written value when im_we=0.
// CONFIGURATION
//   NOP_PAD_EN defined: every BEQ/J/JR is followed by a delay-slot word
//     0x00000000, written at the next address in the PAD cycle (N+2). It counts
//     as a word. If full after the branch word, the pad is dropped.
//   NOP_PAD_EN undefined: no PAD state; branches write a single word.
// TESTING
//   reset, start_i, LW rs=1 rt=2 imm=0x0004 -> im_we@N+1, addr 0x000, data 0x8C220004
//   ADD rs=1 rt=2 rd=3 then ANDI rs=4 rt=5 imm=0x00FF -> 0x00221820@0x000,
//     0x308500FF@0x004, word_count=2
//   BEQ rs=1 rt=2 imm=0xFFFF, JR rs=31, J target=0x10 -> 0x1022FFFF, 0x03E00008,
//     0x08000010; with NOP_PAD_EN a 0x00000000 follows each, count=6, else 3
//   kind=14 -> no im_we, err_illegal=1; start_i -> err_illegal=0, count=0, addr=0
//   DEPTH=4: 5 requests -> 4 writes, full=1, in_ready=0; start_i and in_valid
//     in the same cycle -> start wins, no accept
//   rst_n low in the WRITE cycle -> next cycle im_we=0, count=0, addr=BASE_ADDR

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs symbolic MIPS-Lite requests into 32-bit words and streams them into instruction memory.
// Optional build macro NOP_PAD_EN appends a zero delay-slot word after BEQ/J/JR.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_kind,
  input  logic [4:0]                   in_rs,
  input  logic [4:0]                   in_rt,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_shamt,
  input  logic [15:0]                  in_imm,
  input  logic [25:0]                  in_target,
  output logic                         im_we,
  output logic [ADDR_W-1:0]            im_addr,
  output logic [31:0]                  im_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   word_count,
  output logic                         full,
  output logic                         err_illegal
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

`ifdef NOP_PAD_EN
  typedef enum logic [1:0] {IDLE, WRITE, PAD} state_t;
  logic branch, pad_pend;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t      state;
  logic [31:0] enc;
  logic        legal;
  logic        last;

  assign in_ready = (state == IDLE) && !full && !start_i;
  assign last     = (word_count == CNT_W'(DEPTH - 1));

  always_comb begin
    enc   = '0;
    legal = 1'b1;
`ifdef NOP_PAD_EN
    branch = (in_kind == 4'd6) || (in_kind == 4'd11) || (in_kind == 4'd12);
`endif
    case (in_kind)
      4'd0:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd32};
      4'd1:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd34};
      4'd2:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd36};
      4'd3:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd37};
      4'd4:  enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd42};
      4'd5:  enc = {6'd0, 5'd0, in_rt, in_rd, in_shamt, 6'd2};
      4'd6:  enc = {6'd0, in_rs, 15'd0, 6'd8};
      4'd7:  enc = {6'd0, in_rs, in_rt, 10'd0, 6'd25};
      4'd8:  enc = {6'd12, in_rs, in_rt, in_imm};
      4'd9:  enc = {6'd35, in_rs, in_rt, in_imm};
      4'd10: enc = {6'd43, in_rs, in_rt, in_imm};
      4'd11: enc = {6'd4, in_rs, in_rt, in_imm};
      4'd12: enc = {6'd2, in_target};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      im_we       <= 1'b0;
      im_addr     <= BASE;
      im_wdata    <= '0;
      word_count  <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
`ifdef NOP_PAD_EN
      pad_pend    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            im_addr     <= BASE;
            word_count  <= '0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
          end else if (in_valid && !full) begin
            if (legal) begin
              state    <= WRITE;
              im_we    <= 1'b1;
              im_wdata <= enc;
`ifdef NOP_PAD_EN
              pad_pend <= branch;
`endif
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        WRITE: begin
          im_addr    <= im_addr + ADDR_W'(4);
          word_count <= word_count + CNT_W'(1);
          full       <= last;
`ifdef NOP_PAD_EN
          // the pad is dropped when the branch word itself filled the program
          if (pad_pend && !last) begin
            state    <= PAD;
            im_wdata <= '0;
          end else begin
            state <= IDLE;
            im_we <= 1'b0;
          end
`else
          state <= IDLE;
          im_we <= 1'b0;
`endif
        end
`ifdef NOP_PAD_EN
        PAD: begin
          im_addr    <= im_addr + ADDR_W'(4);
          word_count <= word_count + CNT_W'(1);
          full       <= last;
          state      <= IDLE;
          im_we      <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
          im_we <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader against a word-level program model.
module tb_instr_encoder_loader;
  localparam int AW   = 5;
  localparam int BASE = 8;
  localparam int DEP  = 8;
  localparam int CW   = $clog2(DEP+1);
`ifdef NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_kind = '0;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic im_we, full, err_illegal;
  logic [AW-1:0] im_addr;
  logic [31:0] im_wdata;
  logic [CW-1:0] word_count;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .word_count(word_count), .full(full), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int m_ptr, m_cnt;
  bit m_err;
  logic [31:0] m_last;

  // Reference encoding built from the field layout with plain arithmetic.
  function automatic logic [31:0] ref_enc(int k, int rs, int rt, int rd, int sh, int imm, int tgt);
    longint w;
    longint fn [5] = '{32, 34, 36, 37, 42};
    longint op [4] = '{12, 35, 43, 4};
    longint r = longint'(rs) * 2097152, t = longint'(rt) * 65536, d = longint'(rd) * 2048;
    w = 0;
    if (k <= 4)       w = r + t + d + fn[k];
    else if (k == 5)  w = t + d + longint'(sh) * 64 + 2;
    else if (k == 6)  w = r + 8;
    else if (k == 7)  w = r + t + 25;
    else if (k <= 11) w = op[k-8] * 67108864 + r + t + imm;
    else if (k == 12) w = 2 * 67108864 + longint'(tgt);
    return w[31:0];
  endfunction

  task automatic advance();
    m_ptr = (m_ptr + 4) % (2 ** AW);
    m_cnt++;
  endtask

  task automatic check_idle(string tag);
    logic [AW-1:0] ea = m_ptr[AW-1:0];
    logic [CW-1:0] ec = m_cnt[CW-1:0];
    n_cmp++; if (im_we !== 1'b0) begin n_bad++; $display("FAIL %s im_we got %b want 0", tag, im_we); end
    n_cmp++; if (word_count !== ec) begin n_bad++; $display("FAIL %s word_count got %0d want %0d", tag, word_count, m_cnt); end
    n_cmp++; if (im_addr !== ea) begin n_bad++; $display("FAIL %s im_addr got %h want %h", tag, im_addr, ea); end
    n_cmp++; if (full !== (m_cnt == DEP)) begin n_bad++; $display("FAIL %s full got %b want %b", tag, full, m_cnt == DEP); end
    n_cmp++; if (err_illegal !== m_err) begin n_bad++; $display("FAIL %s err_illegal got %b want %b", tag, err_illegal, m_err); end
    n_cmp++; if (im_wdata !== m_last) begin n_bad++; $display("FAIL %s im_wdata hold got %h want %h", tag, im_wdata, m_last); end
  endtask

  task automatic do_req(int k, int rs, int rt, int rd, int sh, int imm, int tgt);
    bit rdy = (m_cnt < DEP);
    logic [AW-1:0] ea;
    logic [31:0] ew = ref_enc(k, rs, rt, rd, sh, imm, tgt);
    in_kind = 4'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tgt); in_valid = 1'b1; start_i = 1'b0;
    #1;
    n_cmp++; if (in_ready !== rdy) begin n_bad++; $display("FAIL in_ready got %b want %b", in_ready, rdy); end
    @(negedge clk); in_valid = 1'b0;
    if (rdy && k <= 12) begin
      ea = m_ptr[AW-1:0];
      n_cmp++; if (im_we !== 1'b1) begin n_bad++; $display("FAIL write_we kind %0d got %b want 1", k, im_we); end
      n_cmp++; if (im_addr !== ea) begin n_bad++; $display("FAIL write_addr got %h want %h", im_addr, ea); end
      n_cmp++; if (im_wdata !== ew) begin n_bad++; $display("FAIL write_data kind %0d got %h want %h", k, im_wdata, ew); end
      m_last = ew; advance();
      if (PAD_EN && (k == 6 || k == 11 || k == 12) && m_cnt < DEP) begin
        @(negedge clk);
        ea = m_ptr[AW-1:0];
        n_cmp++; if (im_we !== 1'b1) begin n_bad++; $display("FAIL pad_we got %b want 1", im_we); end
        n_cmp++; if (im_addr !== ea) begin n_bad++; $display("FAIL pad_addr got %h want %h", im_addr, ea); end
        n_cmp++; if (im_wdata !== 32'h0) begin n_bad++; $display("FAIL pad_data got %h want 0", im_wdata); end
        m_last = 32'h0; advance();
      end
      @(negedge clk);
    end else if (rdy) begin
      m_err = 1'b1;
    end
    check_idle("after_req");
  endtask

  task automatic do_start();
    start_i = 1'b1; in_valid = 1'b1; in_kind = 4'd9;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL start_ready got %b want 0", in_ready); end
    @(negedge clk); start_i = 1'b0; in_valid = 1'b0;
    m_ptr = BASE; m_cnt = 0; m_err = 1'b0;
    check_idle("start");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = BASE; m_cnt = 0; m_err = 1'b0; m_last = 32'h0;
    check_idle("reset");
  endtask

  task automatic test_directed();
    do_start();
    do_req(9, 1, 2, 0, 0, 16'h0004, 0);
    do_req(0, 1, 2, 3, 7, 0, 0);
    do_req(8, 4, 5, 0, 0, 16'h00FF, 0);
    do_start();
    do_req(11, 1, 2, 0, 0, 16'hFFFF, 0);
    do_req(6, 31, 0, 0, 0, 0, 0);
    do_req(12, 0, 0, 0, 0, 0, 26'h10);
    do_req(14, 1, 2, 3, 0, 0, 0);
    do_req(5, 9, 10, 11, 12, 0, 0);
    do_req(7, 3, 4, 0, 0, 0, 0);
    do_req(10, 29, 8, 0, 0, 16'h8000, 0);
    do_start();
  endtask

  task automatic test_full();
    do_start();
    for (int i = 0; i < DEP + 2; i++)
      do_req(i % 5, $urandom % 32, $urandom % 32, $urandom % 32, 0, 0, 0);
    do_start();
  endtask

  task automatic test_reset_in_write();
    do_start();
    do_req(1, 1, 2, 3, 0, 0, 0);
    in_kind = 4'd9; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_ptr = BASE; m_cnt = 0; m_err = 1'b0; m_last = 32'h0;
    check_idle("reset_in_write");
  endtask

  task automatic test_random();
    do_start();
    for (int i = 0; i < 120; i++) begin
      if (($urandom % 12) == 0) do_start();
      else do_req($urandom % 16, $urandom % 32, $urandom % 32, $urandom % 32, $urandom % 32,
                  $urandom % 65536, $urandom % (1 << 26));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_full();
    test_reset_in_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
